central_alarme: RTL and testbench

CENTRAL_ALARME -- requirements
Module: central_alarme

---
 rtl/central_alarme_pkg.sv | 29 ++
 rtl/central_alarme_contador_regressivo.sv | 54 +++++
 rtl/central_alarme.sv | 170 +++++++++++++++++
 tb/tb_central_alarme.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/central_alarme_pkg.sv
// ---------------------------------------------------------------------------
// central_alarme_pkg
// Shared definitions for the alarm central: state encoding, default timing
// constants and zone helpers used by central_alarme and its countdown.
// No ports (package).
// ---------------------------------------------------------------------------
package central_alarme_pkg;

  // State codes are visible on the estado output, so the encoding is fixed.
  typedef enum logic [1:0] {
    DESARMADO      = 2'b00,
    ARMADO         = 2'b01,
    ESPERA_ENTRADA = 2'b10,
    DISPARADO      = 2'b11
  } estado_t;

  // Default durations in clock cycles (the clock runs at 1 Hz, so seconds).
  localparam int unsigned TEMPO_ENTRADA_PADRAO = 30;
  localparam int unsigned TEMPO_SIRENE_PADRAO  = 180;

  // Bit 0 is the delayed entry door, bits 3:1 fire the siren immediately.
  localparam logic [3:0] ZONA_ENTRADA        = 4'b0001;
  localparam logic [3:0] MASCARA_INSTANTANEA = 4'b1110;

  function automatic logic [3:0] zonas_instantaneas(input logic [3:0] sens);
    return sens & MASCARA_INSTANTANEA;
  endfunction

endpackage

// File: rtl/central_alarme_contador_regressivo.sv
// ---------------------------------------------------------------------------
// contador_regressivo
// 8-bit loadable down-counter that saturates at zero.
// Ports:
//   clk_i       clock, rising edge
//   rst_i       asynchronous active-high reset, clears the count
//   clr_i       synchronous clear (highest priority)
//   load_i      synchronous load of valor_i
//   dec_i       decrement by one, holds at zero
//   valor_i     load value
//   contagem_o  current count
//   zero_o      count is zero
//   ultimo_o    count is one, i.e. the next decrement reaches zero
// ---------------------------------------------------------------------------
module contador_regressivo (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       clr_i,
  input  logic       load_i,
  input  logic       dec_i,
  input  logic [7:0] valor_i,
  output logic [7:0] contagem_o,
  output logic       zero_o,
  output logic       ultimo_o
);

  logic [7:0] contagem_q;
  logic [7:0] contagem_d;

  // Clear beats load beats decrement; a decrement at zero leaves it at zero.
  always_comb begin
    contagem_d = contagem_q;
    if (clr_i) begin
      contagem_d = '0;
    end else if (load_i) begin
      contagem_d = valor_i;
    end else if (dec_i && (contagem_q != 8'd0)) begin
      contagem_d = contagem_q - 8'd1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      contagem_q <= '0;
    end else begin
      contagem_q <= contagem_d;
    end
  end

  assign contagem_o = contagem_q;
  assign zero_o     = (contagem_q == 8'd0);
  assign ultimo_o   = (contagem_q == 8'd1);

endmodule

// File: rtl/central_alarme.sv
// ---------------------------------------------------------------------------
// central_alarme
// Four-zone burglar alarm controller: synchronizes the zone sensors, runs the
// arm / entry-delay / siren state machine, and latches the zones that caused
// an alarm since the last arming.
// Ports:
//   gerador_frequencia  1 Hz clock, rising edge
//   reset               asynchronous active-high reset
//   habilitador         1 = armed request, 0 = disarm
//   sensores[3:0]       zone sensors (bit 0 entry door, 3:1 instant zones)
//   sirene              registered siren drive
//   estado[1:0]         current state code
//   tempo_restante[7:0] remaining cycles of the active countdown, else 0
//   zona_disparo[3:0]   zones that caused alarms since last arming
// ---------------------------------------------------------------------------
module central_alarme
  import central_alarme_pkg::*;
#(
  parameter int unsigned TEMPO_ENTRADA = TEMPO_ENTRADA_PADRAO,
  parameter int unsigned TEMPO_SIRENE  = TEMPO_SIRENE_PADRAO
) (
  input  logic       gerador_frequencia,
  input  logic       reset,
  input  logic       habilitador,
  input  logic [3:0] sensores,
  output logic       sirene,
  output logic [1:0] estado,
  output logic [7:0] tempo_restante,
  output logic [3:0] zona_disparo
);

  localparam logic [7:0] CARGA_ENTRADA = TEMPO_ENTRADA[7:0];
  localparam logic [7:0] CARGA_SIRENE  = TEMPO_SIRENE[7:0];

  logic [3:0] sens_meta_q;
  logic [3:0] sens_sinc_q;
  estado_t    estado_q;
  estado_t    estado_d;
  logic       sirene_q;
  logic [3:0] zona_q;
  logic [3:0] zona_d;

  logic       cnt_clr;
  logic       cnt_load;
  logic       cnt_dec;
  logic [7:0] cnt_valor;
  logic [7:0] cnt_contagem;
  logic       cnt_zero;
  logic       cnt_ultimo;

  logic [3:0] instantaneas;
  logic       inst_ativa;
  logic       expirou;

  assign instantaneas = zonas_instantaneas(sens_sinc_q);
  assign inst_ativa   = |instantaneas;
  // The countdown ends on the edge that would take it from 1 to 0, so an
  // N-cycle load gives exactly N cycles in the state; zero covers saturation.
  assign expirou      = cnt_ultimo | cnt_zero;

  contador_regressivo u_contador (
    .clk_i      (gerador_frequencia),
    .rst_i      (reset),
    .clr_i      (cnt_clr),
    .load_i     (cnt_load),
    .dec_i      (cnt_dec),
    .valor_i    (cnt_valor),
    .contagem_o (cnt_contagem),
    .zero_o     (cnt_zero),
    .ultimo_o   (cnt_ultimo)
  );

  // Next-state and countdown control. In every armed state a disarm wins,
  // then an instant zone, then the entry door or the entry timeout.
  always_comb begin
    estado_d  = estado_q;
    zona_d    = zona_q;
    cnt_clr   = 1'b0;
    cnt_load  = 1'b0;
    cnt_dec   = 1'b0;
    cnt_valor = CARGA_ENTRADA;
    case (estado_q)
      DESARMADO: begin
        cnt_clr = 1'b1;
        if (habilitador) begin
          estado_d = ARMADO;
          zona_d   = '0;
        end
      end
      ARMADO: begin
        if (!habilitador) begin
          estado_d = DESARMADO;
          cnt_clr  = 1'b1;
        end else if (inst_ativa) begin
          estado_d  = DISPARADO;
          cnt_load  = 1'b1;
          cnt_valor = CARGA_SIRENE;
          zona_d    = zona_q | instantaneas;
        end else if (sens_sinc_q[0]) begin
          estado_d  = ESPERA_ENTRADA;
          cnt_load  = 1'b1;
          cnt_valor = CARGA_ENTRADA;
        end else begin
          cnt_clr = 1'b1;
        end
      end
      ESPERA_ENTRADA: begin
        if (!habilitador) begin
          estado_d = DESARMADO;
          cnt_clr  = 1'b1;
        end else if (inst_ativa) begin
          estado_d  = DISPARADO;
          cnt_load  = 1'b1;
          cnt_valor = CARGA_SIRENE;
          zona_d    = zona_q | instantaneas;
        end else if (expirou) begin
          estado_d  = DISPARADO;
          cnt_load  = 1'b1;
          cnt_valor = CARGA_SIRENE;
          zona_d    = zona_q | ZONA_ENTRADA;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      DISPARADO: begin
        if (!habilitador) begin
          estado_d = DESARMADO;
          cnt_clr  = 1'b1;
        end else begin
          zona_d = zona_q | sens_sinc_q;
          if (expirou) begin
            estado_d = ARMADO;
            cnt_clr  = 1'b1;
          end else begin
            cnt_dec = 1'b1;
          end
        end
      end
      default: begin
        estado_d = DESARMADO;
        cnt_clr  = 1'b1;
      end
    endcase
  end

  // Two-flop synchronizer plus the state, zone latch and registered siren.
  // The siren follows the next state so it rises with estado=DISPARADO.
  always_ff @(posedge gerador_frequencia or posedge reset) begin
    if (reset) begin
      sens_meta_q <= '0;
      sens_sinc_q <= '0;
      estado_q    <= DESARMADO;
      sirene_q    <= 1'b0;
      zona_q      <= '0;
    end else begin
      sens_meta_q <= sensores;
      sens_sinc_q <= sens_meta_q;
      estado_q    <= estado_d;
      sirene_q    <= (estado_d == DISPARADO);
      zona_q      <= zona_d;
    end
  end

  assign sirene         = sirene_q;
  assign estado         = estado_q;
  assign zona_disparo   = zona_q;
  assign tempo_restante = ((estado_q == ESPERA_ENTRADA) || (estado_q == DISPARADO))
                          ? cnt_contagem : 8'd0;

endmodule

// File: tb/tb_central_alarme.sv
// ---------------------------------------------------------------------------
// tb_central_alarme
// Directed scoreboard bench for central_alarme: the stimulus process queues
// hand-computed expectations tagged with the clock cycle at which they hold,
// and a monitor compares them on the falling edge of that cycle.
// ---------------------------------------------------------------------------
module tb_central_alarme;

  logic       gerador_frequencia = 1'b0;
  logic       reset;
  logic       habilitador;
  logic [3:0] sensores;
  logic       sirene;
  logic [1:0] estado;
  logic [7:0] tempo_restante;
  logic [3:0] zona_disparo;

  int ciclo   = 0;
  int vetores = 0;
  int falhas  = 0;

  typedef struct packed {
    logic [127:0] nome;
    int           tag;
    logic [1:0]   est;
    logic         sir;
    logic [7:0]   tempo;
    logic [3:0]   zona;
  } esperado_t;

  esperado_t fila[$];
  esperado_t restantes[$];

  central_alarme #(
    .TEMPO_ENTRADA (30),
    .TEMPO_SIRENE  (180)
  ) dut (
    .gerador_frequencia (gerador_frequencia),
    .reset              (reset),
    .habilitador        (habilitador),
    .sensores           (sensores),
    .sirene             (sirene),
    .estado             (estado),
    .tempo_restante     (tempo_restante),
    .zona_disparo       (zona_disparo)
  );

  // Free-running clock; each rising edge advances the cycle number.
  always #5 gerador_frequencia = ~gerador_frequencia;

  always @(posedge gerador_frequencia) ciclo <= ciclo + 1;

  task automatic applyStimulus(input logic hab, input logic [3:0] sens);
    habilitador = hab;
    sensores    = sens;
  endtask

  task automatic checkOutput(input logic [127:0] nome, input int atraso,
                             input logic [1:0] est, input logic sir,
                             input logic [7:0] tempo, input logic [3:0] zona);
    esperado_t e;
    e.nome  = nome;
    e.tag   = ciclo + atraso;
    e.est   = est;
    e.sir   = sir;
    e.tempo = tempo;
    e.zona  = zona;
    fila.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge gerador_frequencia);
  endtask

  // Monitor: on each falling edge compare every expectation due this cycle;
  // an expectation whose cycle already passed counts as a miscompare.
  always @(negedge gerador_frequencia) begin
    restantes.delete();
    foreach (fila[i]) begin
      if (fila[i].tag == ciclo) begin
        vetores++;
        if ((estado !== fila[i].est) || (sirene !== fila[i].sir) ||
            (tempo_restante !== fila[i].tempo) || (zona_disparo !== fila[i].zona)) begin
          falhas++;
          $display("[TB] FAIL %0s cycle %0d: got estado=%b sirene=%b tempo_restante=%0d zona_disparo=%b, required estado=%b sirene=%b tempo_restante=%0d zona_disparo=%b",
                   fila[i].nome, ciclo, estado, sirene, tempo_restante, zona_disparo,
                   fila[i].est, fila[i].sir, fila[i].tempo, fila[i].zona);
        end
      end else if (fila[i].tag < ciclo) begin
        vetores++;
        falhas++;
        $display("[TB] FAIL %0s: expectation for cycle %0d never sampled (now %0d)",
                 fila[i].nome, fila[i].tag, ciclo);
      end else begin
        restantes.push_back(fila[i]);
      end
    end
    fila = restantes;
  end

  // Directed scenario sequence; comments give the cycle reached after tick.
  initial begin
    reset = 1'b1;
    applyStimulus(1'b0, 4'b0000);

    tick(1);
    checkOutput("reset_state", 1, 2'b00, 1'b0, 8'd0, 4'b0000);
    tick(1);
    reset = 1'b0;
    applyStimulus(1'b1, 4'b0000);
    checkOutput("arm", 1, 2'b01, 1'b0, 8'd0, 4'b0000);

    tick(1);
    applyStimulus(1'b1, 4'b0001);
    checkOutput("entry_start", 3, 2'b10, 1'b0, 8'd30, 4'b0000);
    tick(1);
    applyStimulus(1'b1, 4'b0000);
    checkOutput("entry_count21", 11, 2'b10, 1'b0, 8'd21, 4'b0000);
    checkOutput("entry_count12", 20, 2'b10, 1'b0, 8'd12, 4'b0000);
    tick(20);
    applyStimulus(1'b0, 4'b0000);
    checkOutput("entry_disarm", 1, 2'b00, 1'b0, 8'd0, 4'b0000);

    tick(1);
    applyStimulus(1'b1, 4'b0000);
    checkOutput("rearm_1", 1, 2'b01, 1'b0, 8'd0, 4'b0000);
    tick(1);
    applyStimulus(1'b1, 4'b0001);
    checkOutput("entry_held_30", 3, 2'b10, 1'b0, 8'd30, 4'b0000);
    checkOutput("entry_last", 32, 2'b10, 1'b0, 8'd1, 4'b0000);
    checkOutput("entry_timeout", 33, 2'b11, 1'b1, 8'd180, 4'b0001);
    checkOutput("siren_179", 34, 2'b11, 1'b1, 8'd179, 4'b0001);
    tick(34);
    applyStimulus(1'b0, 4'b0000);
    checkOutput("siren_disarm", 1, 2'b00, 1'b0, 8'd0, 4'b0001);

    tick(1);
    applyStimulus(1'b1, 4'b0000);
    checkOutput("rearm_2", 1, 2'b01, 1'b0, 8'd0, 4'b0000);
    tick(1);
    applyStimulus(1'b1, 4'b0100);
    checkOutput("instant_fire", 3, 2'b11, 1'b1, 8'd180, 4'b0100);
    checkOutput("instant_last", 182, 2'b11, 1'b1, 8'd1, 4'b0100);
    checkOutput("instant_end", 183, 2'b01, 1'b0, 8'd0, 4'b0100);
    tick(1);
    applyStimulus(1'b1, 4'b0000);

    tick(182);
    applyStimulus(1'b1, 4'b0011);
    checkOutput("simul_pre", 1, 2'b01, 1'b0, 8'd0, 4'b0100);
    tick(1);
    applyStimulus(1'b0, 4'b0011);
    checkOutput("simul_disarm", 1, 2'b00, 1'b0, 8'd0, 4'b0100);
    checkOutput("simul_hold", 2, 2'b00, 1'b0, 8'd0, 4'b0100);
    tick(1);
    applyStimulus(1'b0, 4'b0000);

    tick(1);
    applyStimulus(1'b1, 4'b0000);
    checkOutput("rearm_3", 1, 2'b01, 1'b0, 8'd0, 4'b0000);
    tick(1);
    applyStimulus(1'b1, 4'b1000);
    checkOutput("zone3_fire", 3, 2'b11, 1'b1, 8'd180, 4'b1000);
    checkOutput("siren_98", 85, 2'b11, 1'b1, 8'd98, 4'b1000);
    tick(85);

    @(posedge gerador_frequencia);
    #1;
    reset = 1'b1;
    applyStimulus(1'b0, 4'b0000);
    checkOutput("async_reset", 0, 2'b00, 1'b0, 8'd0, 4'b0000);
    checkOutput("reset_hold", 1, 2'b00, 1'b0, 8'd0, 4'b0000);
    tick(2);
    reset = 1'b0;
    applyStimulus(1'b1, 4'b0000);
    checkOutput("post_reset_arm", 1, 2'b01, 1'b0, 8'd0, 4'b0000);

    tick(3);
    foreach (fila[i]) begin
      vetores++;
      falhas++;
      $display("[TB] FAIL %0s: expectation for cycle %0d left unchecked", fila[i].nome, fila[i].tag);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vetores, falhas);
    $finish;
  end

endmodule
